// File: rtl/wb_initiator_pkg.sv
// Shared types and widths for the Wishbone classic initiator.
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    localparam int WB_ADR_W            = 32;
    localparam int WB_DAT_W            = 32;
    localparam int WB_SEL_W            = 4;
    localparam int TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic master bridging a valid/ready command/response pair.
// Define WB_INITIATOR_TIMEOUT_EN to abort a REQ phase after TIMEOUT_CYC cycles without ack.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    output logic                busy
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
        $error("wb_initiator: TIMEOUT_CYC out of range 1..65535");
    end

    state_e state, state_nxt;
    logic   accept;
    logic   timeout;

    assign accept    = cmd_valid && (state == IDLE);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RSP);
    assign wbm_cyc_o = (state == REQ);
    assign wbm_stb_o = (state == REQ);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = REQ;
            REQ:     if (wbm_ack_i || timeout) state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields stay latched from accept until the next accept, so they are stable through REQ.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat   <= '0;
        end else begin
            if (accept) begin
                wbm_we_o  <= cmd_we;
                wbm_sel_o <= cmd_sel;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
            end
            if (state == REQ && wbm_ack_i) rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
            else if (state == REQ && timeout) rsp_dat <= '0;
        end
    end

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        rsp_err_q;

    // to_cnt holds the number of completed REQ cycles; abort on the TIMEOUT_CYC-th one.
    assign timeout = (state == REQ) && (to_cnt == 16'(TIMEOUT_CYC - 1));
    assign rsp_err = rsp_err_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept)              to_cnt <= '0;
            else if (state == REQ)   to_cnt <= to_cnt + 16'd1;
            if (state == REQ && (wbm_ack_i || timeout)) rsp_err_q <= !wbm_ack_i;
        end
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the number of cycles with stb high and no ack before abort (range 1..65535).
REQ-002 SHALL have port wb_clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_sel in 4, cmd_adr in 32, cmd_dat in 32: the command request channel.
REQ-005 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_dat out 32, rsp_err out 1: the response channel.
REQ-006 SHALL have wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_sel_o out 4; wbm_adr_o, wbm_dat_o out 32: the Wishbone classic master outputs.
REQ-007 SHALL have wbm_ack_i in 1 and wbm_dat_i in 32: the Wishbone slave return.
REQ-008 SHALL have busy, out, 1, asserted whenever state is not IDLE.

Function
REQ-009 SHALL implement an FSM with states IDLE, REQ and RSP.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-011 SHALL register we/sel/adr/dat on accept, go to REQ and assert wbm_cyc_o=wbm_stb_o=1 from the next cycle.
REQ-012 SHALL hold all wbm_* outputs stable throughout REQ.
REQ-013 SHALL, on a sampled wbm_ack_i in REQ, deassert cyc/stb on that edge, set rsp_valid=1, set rsp_err=0 and go to RSP.
REQ-014 SHALL load rsp_dat with wbm_dat_i for reads and with 0 for writes.
REQ-015 SHALL, when ack is sampled in cycle M, present rsp_valid in cycle M+1; minimum command-to-response time is 3 cycles.
REQ-016 SHALL hold rsp_valid, rsp_dat and rsp_err stable in RSP until rsp_ready=1, then return to IDLE, with cmd_ready=1 on the next cycle.
REQ-017 SHALL ignore wbm_ack_i in IDLE and RSP.
REQ-018 SHALL have no back-to-back pipelining: one outstanding transaction maximum.

Reset
REQ-019 SHALL, with wb_rst_i high at an edge, force state to IDLE with all outputs 0 except cmd_ready=1, and clear the timeout counter.
REQ-020 SHALL, on reset mid-REQ, drop cyc/stb on that edge and discard the transaction with no response; on reset in RSP, discard the pending response.

Configuration
REQ-021 SHALL, with macro WB_INITIATOR_TIMEOUT_EN defined, run a 16-bit counter in REQ, cleared on entry to REQ.
REQ-022 SHALL, with WB_INITIATOR_TIMEOUT_EN defined and the counter reaching TIMEOUT_CYC without ack, drop cyc/stb, set rsp_err=1, rsp_dat=0 and go to RSP.
REQ-023 SHALL give ack priority over timeout when both occur in the same cycle, with rsp_err=0.
REQ-024 SHALL, without WB_INITIATOR_TIMEOUT_EN, contain no counter, hold rsp_err at constant 0 and wait indefinitely in REQ.

Structure
REQ-025 SHALL take the state enum, WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4 and the default TIMEOUT_CYC from shared package wb_initiator_pkg.
REQ-026 SHALL be a single flat module with no sub-module; the timeout counter is inline logic under the macro.

Verification
REQ-027 SHALL pass: read of 0x3000_0000 with ack after 2 cycles and wbm_dat_i=0xDEAD_BEEF -> rsp_valid with rsp_dat=0xDEAD_BEEF, rsp_err=0, cyc/stb high for exactly 3 cycles.
REQ-028 SHALL pass: write of 0x1234_5678 to 0x3800_0004 with sel=0xF -> wbm_we_o=1, adr/dat/sel held until ack, rsp_dat=0.
REQ-029 SHALL pass: rsp_ready held low for 10 cycles -> response stable and cmd_ready=0 throughout; cmd_ready=1 the cycle after rsp_ready rises.
REQ-030 SHALL pass: with the macro defined and TIMEOUT_CYC=8, no ack -> cyc/stb drop after 8 cycles, rsp_err=1, rsp_dat=0; with ack in cycle 8 -> rsp_err=0.
REQ-031 SHALL pass: wb_rst_i pulsed in REQ cycle 2 -> cyc/stb=0 on the next cycle, no rsp_valid, cmd_ready=1.
REQ-032 SHALL pass: spurious wbm_ack_i in IDLE -> no rsp_valid and no state change.
